// File: rtl/lockable_reg_pkg.sv
// Purpose : shared types and constants for the lockable register bank.
// Latency : n/a (declarations only).
// Backpressure: n/a.
//
// Contents: dbg_state_t (debug-session FSM states), default debug keys,
// fail_cnt_w() sizing helper for the wrong-key counter.
package lockable_reg_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_ARMED    = 3'd1,
        ST_ZERO_IN  = 3'd2,
        ST_SESSION  = 3'd3,
        ST_ZERO_OUT = 3'd4,
        ST_LOCKOUT  = 3'd5
    } dbg_state_t;

    localparam logic [31:0] DEF_KEY0 = 32'hA5C3_0F1E;
    localparam logic [31:0] DEF_KEY1 = 32'h5A3C_F0E1;

    // Width needed to hold 0..max_fails inclusive (the counter saturates there).
    function automatic int fail_cnt_w(input int max_fails);
        return (max_fails < 2) ? 1 : $clog2(max_fails + 1);
    endfunction

endpackage

// File: rtl/lock_auth_fsm.sv
// Purpose : debug-session authenticator: two-key challenge, ARMED timeout, wrong-key lockout, zeroize sequencing.
// Latency : state changes one cycle after the qualifying key/exit strobe; each zeroize phase lasts N_REGS cycles.
// Backpressure: none; dbg_req_i/dbg_exit_i are single-cycle strobes, ignored in states that do not use them.
//
// Ports: clk_i, reset_i (sync, active-high); dbg_req_i/dbg_key_i key strobe; dbg_exit_i
// session end; state_o current state; zero_en_o high while zeroizing; zero_idx_o register to clear.
module lock_auth_fsm
    import lockable_reg_pkg::*;
#(
    parameter int              N_REGS    = 8,
    parameter int              KEY_W     = 32,
    parameter logic [KEY_W-1:0] KEY0     = DEF_KEY0,
    parameter logic [KEY_W-1:0] KEY1     = DEF_KEY1,
    parameter int              TIMEOUT   = 16,
    parameter int              MAX_FAILS = 3,
    parameter int              IDX_W     = (N_REGS > 1) ? $clog2(N_REGS) : 1
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             dbg_req_i,
    input  logic [KEY_W-1:0] dbg_key_i,
    input  logic             dbg_exit_i,
    output dbg_state_t       state_o,
    output logic             zero_en_o,
    output logic [IDX_W-1:0] zero_idx_o
);

    localparam int TMR_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam int FC_W  = fail_cnt_w(MAX_FAILS);

    localparam logic [TMR_W-1:0] TMR_INIT = TMR_W'(TIMEOUT - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_REGS - 1);
    localparam logic [FC_W-1:0]  FC_MAX   = FC_W'(MAX_FAILS);

    dbg_state_t       state_q, state_d;
    logic [TMR_W-1:0] timer_q, timer_d;
    logic [FC_W-1:0]  fail_q,  fail_d;
    logic [IDX_W-1:0] idx_q,   idx_d;
    logic             bad_key;

    // State register
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= ST_IDLE;
            timer_q <= '0;
            fail_q  <= '0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            fail_q  <= fail_d;
            idx_q   <= idx_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        fail_d  = fail_q;
        idx_d   = idx_q;
        bad_key = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (dbg_req_i) begin
                    if (dbg_key_i == KEY0) begin
                        state_d = ST_ARMED;
                        timer_d = TMR_INIT;
                    end else begin
                        bad_key = 1'b1;
                    end
                end
            end
            ST_ARMED: begin
                if (dbg_req_i) begin
                    if (dbg_key_i == KEY1) begin
                        state_d = ST_ZERO_IN;
                        idx_d   = '0;
                    end else begin
                        state_d = ST_IDLE;
                        bad_key = 1'b1;
                    end
                end else if (timer_q == '0) begin
                    // Silent expiry: the challenge lapses without counting as a failure.
                    state_d = ST_IDLE;
                end else begin
                    timer_d = timer_q - 1'b1;
                end
            end
            ST_ZERO_IN: begin
                idx_d = idx_q + 1'b1;
                if (idx_q == IDX_LAST) begin
                    state_d = ST_SESSION;
                    idx_d   = '0;
                    fail_d  = '0;
                end
            end
            ST_SESSION: begin
                if (dbg_exit_i) begin
                    state_d = ST_ZERO_OUT;
                    idx_d   = '0;
                end
            end
            ST_ZERO_OUT: begin
                idx_d = idx_q + 1'b1;
                if (idx_q == IDX_LAST) begin
                    state_d = ST_IDLE;
                    idx_d   = '0;
                end
            end
            ST_LOCKOUT: begin
                state_d = ST_LOCKOUT;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Wrong-key accounting overrides the state chosen above once the limit is hit.
        if (bad_key) begin
            if (fail_q >= FC_MAX - 1'b1) begin
                fail_d  = FC_MAX;
                state_d = ST_LOCKOUT;
            end else begin
                fail_d = fail_q + 1'b1;
            end
        end
    end

    // Outputs
    always_comb begin
        state_o    = state_q;
        zero_en_o  = (state_q == ST_ZERO_IN) || (state_q == ST_ZERO_OUT);
        zero_idx_o = idx_q;
    end

endmodule

// File: rtl/lockable_reg_bank.sv
// Purpose : N_REGS x DATA_W config register bank with sticky per-register write locks and authenticated debug override.
// Latency : writes land on the next edge; Data_out is registered (1 cycle); wr_err pulses the cycle after a reject.
// Backpressure: none; rejected writes are dropped and flagged on wr_err, never stalled.
//
// Ports: Clk, reset (sync, active-high); write/wr_addr/Data_in/mode_a write port; rd_addr/Data_out
// read port; Lock/lock_addr/lock_all lock set; dbg_req/dbg_key/dbg_exit debug session control;
// locked_mask, dbg_active, zero_busy, lockout, wr_err status.
module lockable_reg_bank
    import lockable_reg_pkg::*;
#(
    parameter int               N_REGS    = 8,
    parameter int               DATA_W    = 16,
    parameter int               ADDR_W    = $clog2(N_REGS),
    parameter int               KEY_W     = 32,
    parameter logic [KEY_W-1:0] KEY0      = DEF_KEY0,
    parameter logic [KEY_W-1:0] KEY1      = DEF_KEY1,
    parameter int               TIMEOUT   = 16,
    parameter int               MAX_FAILS = 3
) (
    input  logic              Clk,
    input  logic              reset,
    input  logic              write,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] Data_in,
    input  logic              mode_a,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] Data_out,
    input  logic              Lock,
    input  logic [ADDR_W-1:0] lock_addr,
    input  logic              lock_all,
    input  logic              dbg_req,
    input  logic [KEY_W-1:0]  dbg_key,
    input  logic              dbg_exit,
    output logic [N_REGS-1:0] locked_mask,
    output logic              dbg_active,
    output logic              zero_busy,
    output logic              lockout,
    output logic              wr_err
);

    localparam logic [ADDR_W:0] N_REGS_A = (ADDR_W + 1)'(N_REGS);

    logic [DATA_W-1:0] regs_q [N_REGS];
    logic [DATA_W-1:0] regs_d [N_REGS];
    logic [N_REGS-1:0] lock_q, lock_d, lock_set;
    logic [DATA_W-1:0] dout_q, dout_d;
    logic              wr_err_q, wr_err_d;
    logic              wr_accept;
    logic              wr_addr_ok, rd_addr_ok, lock_addr_ok;

    dbg_state_t        state;
    logic              zero_en;
    logic [ADDR_W-1:0] zero_idx;

    lock_auth_fsm #(
        .N_REGS    (N_REGS),
        .KEY_W     (KEY_W),
        .KEY0      (KEY0),
        .KEY1      (KEY1),
        .TIMEOUT   (TIMEOUT),
        .MAX_FAILS (MAX_FAILS),
        .IDX_W     (ADDR_W)
    ) u_auth (
        .clk_i      (Clk),
        .reset_i    (reset),
        .dbg_req_i  (dbg_req),
        .dbg_key_i  (dbg_key),
        .dbg_exit_i (dbg_exit),
        .state_o    (state),
        .zero_en_o  (zero_en),
        .zero_idx_o (zero_idx)
    );

    assign wr_addr_ok   = {1'b0, wr_addr}   < N_REGS_A;
    assign rd_addr_ok   = {1'b0, rd_addr}   < N_REGS_A;
    assign lock_addr_ok = {1'b0, lock_addr} < N_REGS_A;

    always_comb begin
        lock_set = lock_all ? '1 : '0;
        if (Lock && lock_addr_ok) begin
            lock_set[lock_addr] = 1'b1;
        end
    end

    // Write qualification. A lock arriving in the same cycle always beats the write.
    // Outside SESSION (including LOCKOUT) the normal mode_a / lock rules apply; zeroize
    // owns the array so every write is refused while it runs.
    always_comb begin
        wr_accept = 1'b0;
        if (write && wr_addr_ok && !zero_en && !lock_set[wr_addr]) begin
            if (state == ST_SESSION) begin
                wr_accept = 1'b1;
            end else begin
                wr_accept = mode_a && !lock_q[wr_addr];
            end
        end
    end

    always_comb begin
        regs_d = regs_q;
        if (wr_accept) begin
            regs_d[wr_addr] = Data_in;
        end
        if (zero_en) begin
            regs_d[zero_idx] = '0;
        end
        // Reads sample the pre-write array, so a same-cycle write returns the old value.
        dout_d   = rd_addr_ok ? regs_q[rd_addr] : '0;
        wr_err_d = write && !wr_accept;
        lock_d   = lock_q | lock_set;
    end

    always_ff @(posedge Clk) begin
        if (reset) begin
            regs_q   <= '{default: '0};
            lock_q   <= '0;
            dout_q   <= '0;
            wr_err_q <= 1'b0;
        end else begin
            regs_q   <= regs_d;
            lock_q   <= lock_d;
            dout_q   <= dout_d;
            wr_err_q <= wr_err_d;
        end
    end

    assign Data_out    = dout_q;
    assign locked_mask = lock_q;
    assign dbg_active  = (state == ST_SESSION);
    assign zero_busy   = zero_en;
    assign lockout     = (state == ST_LOCKOUT);
    assign wr_err      = wr_err_q;

endmodule

// File: tb/tb_lockable_reg_bank.sv
// Purpose : self-checking bench for lockable_reg_bank: directed scenarios plus randomized traffic.
// Latency : reference model advances on posedge; outputs compared every negedge.
// Backpressure: n/a.
module tb_lockable_reg_bank;

    localparam int          N    = 8;
    localparam logic [31:0] K0   = 32'hA5C3_0F1E;
    localparam logic [31:0] K1   = 32'h5A3C_F0E1;
    localparam int          TMO  = 16;
    localparam int          MAXF = 3;

    localparam int P_IDLE = 0, P_ARMED = 1, P_ZIN = 2, P_SESSION = 3, P_ZOUT = 4, P_LOCK = 5;

    logic        Clk = 1'b0;
    logic        reset, write, mode_a, Lock, lock_all, dbg_req, dbg_exit;
    logic [2:0]  wr_addr, rd_addr, lock_addr;
    logic [15:0] Data_in;
    logic [31:0] dbg_key;
    logic [15:0] Data_out;
    logic [7:0]  locked_mask;
    logic        dbg_active, zero_busy, lockout, wr_err;

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_en   = 1'b0;

    always #5 Clk = ~Clk;

    lockable_reg_bank dut (
        .Clk         (Clk),
        .reset       (reset),
        .write       (write),
        .wr_addr     (wr_addr),
        .Data_in     (Data_in),
        .mode_a      (mode_a),
        .rd_addr     (rd_addr),
        .Data_out    (Data_out),
        .Lock        (Lock),
        .lock_addr   (lock_addr),
        .lock_all    (lock_all),
        .dbg_req     (dbg_req),
        .dbg_key     (dbg_key),
        .dbg_exit    (dbg_exit),
        .locked_mask (locked_mask),
        .dbg_active  (dbg_active),
        .zero_busy   (zero_busy),
        .lockout     (lockout),
        .wr_err      (wr_err)
    );

    // ---------------- reference model ----------------
    logic [15:0] m_regs [N];
    logic [7:0]  m_lock  = '0;
    logic [15:0] m_dout  = '0;
    bit          m_wrerr = 1'b0;
    int          m_phase = P_IDLE;
    int          m_left  = 0;   // ARMED cycles remaining before the challenge lapses
    int          m_zidx  = 0;
    int          m_fails = 0;

    task automatic m_wrong_key();
        m_fails = (m_fails < MAXF) ? m_fails + 1 : MAXF;
        if (m_fails >= MAXF) m_phase = P_LOCK;
    endtask

    always @(posedge Clk) begin : ref_model
        logic [7:0] lset;
        bit busy, acc;
        if (reset) begin
            for (int i = 0; i < N; i++) m_regs[i] = '0;
            m_lock = '0; m_dout = '0; m_wrerr = 1'b0;
            m_phase = P_IDLE; m_left = 0; m_zidx = 0; m_fails = 0;
        end else begin
            lset = lock_all ? 8'hFF : 8'h00;
            if (Lock) lset[lock_addr] = 1'b1;
            busy = (m_phase == P_ZIN) || (m_phase == P_ZOUT);
            acc  = write && !busy && (int'(wr_addr) < N) && !lset[wr_addr] &&
                   ((m_phase == P_SESSION) || (mode_a && !m_lock[wr_addr]));
            m_dout  = (int'(rd_addr) < N) ? m_regs[rd_addr] : 16'h0;
            m_wrerr = write && !acc;
            if (acc)  m_regs[wr_addr] = Data_in;
            if (busy) m_regs[m_zidx] = '0;
            m_lock = m_lock | lset;
            case (m_phase)
                P_IDLE: if (dbg_req) begin
                    if (dbg_key == K0) begin m_phase = P_ARMED; m_left = TMO; end
                    else m_wrong_key();
                end
                P_ARMED: begin
                    if (dbg_req) begin
                        if (dbg_key == K1) begin m_phase = P_ZIN; m_zidx = 0; end
                        else begin m_phase = P_IDLE; m_wrong_key(); end
                    end else begin
                        m_left = m_left - 1;
                        if (m_left == 0) m_phase = P_IDLE;
                    end
                end
                P_ZIN: begin
                    m_zidx = m_zidx + 1;
                    if (m_zidx == N) begin m_phase = P_SESSION; m_zidx = 0; m_fails = 0; end
                end
                P_SESSION: if (dbg_exit) begin m_phase = P_ZOUT; m_zidx = 0; end
                P_ZOUT: begin
                    m_zidx = m_zidx + 1;
                    if (m_zidx == N) begin m_phase = P_IDLE; m_zidx = 0; end
                end
                default: ;
            endcase
        end
    end

    // ---------------- checking ----------------
    task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge Clk) begin
        if (chk_en) begin
            cmp("Data_out",    32'(Data_out),    32'(m_dout));
            cmp("locked_mask", 32'(locked_mask), 32'(m_lock));
            cmp("wr_err",      32'(wr_err),      32'(m_wrerr));
            cmp("dbg_active",  32'(dbg_active),  32'(m_phase == P_SESSION));
            cmp("zero_busy",   32'(zero_busy),   32'((m_phase == P_ZIN) || (m_phase == P_ZOUT)));
            cmp("lockout",     32'(lockout),     32'(m_phase == P_LOCK));
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic step();
        @(negedge Clk);
    endtask

    task automatic clear_in();
        reset = 0; write = 0; mode_a = 0; Lock = 0; lock_all = 0; dbg_req = 0; dbg_exit = 0;
        wr_addr = 0; rd_addr = 0; lock_addr = 0; Data_in = 0; dbg_key = 0;
    endtask

    task automatic send_key(input logic [31:0] k);
        dbg_req = 1; dbg_key = k;
        step();
        dbg_req = 0;
    endtask

    // Counts consecutive samples with zero_busy high, bounded so a stuck DUT cannot hang the run.
    task automatic count_busy(output int n);
        n = 0;
        while (zero_busy === 1'b1 && n < 20) begin
            n++;
            step();
        end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int nb;
        logic [31:0] k;
        clear_in();

        // Reset state
        reset = 1;
        step(); step();
        chk_en = 1;
        cmp("rst_Data_out", 32'(Data_out), 32'h0);
        cmp("rst_mask",     32'(locked_mask), 32'h0);
        cmp("rst_lockout",  32'(lockout), 32'h0);
        reset = 0;

        // 1: locked register refuses writes
        Lock = 1; lock_addr = 2; step(); Lock = 0;
        write = 1; wr_addr = 2; Data_in = 16'hBEEF; mode_a = 1; step(); write = 0;
        cmp("t1_wr_err", 32'(wr_err), 32'h1);
        cmp("t1_mask",   32'(locked_mask), 32'h04);
        rd_addr = 2; step();
        cmp("t1_reg2",   32'(Data_out), 32'h0);

        // 2: mode_a gating
        write = 1; wr_addr = 1; Data_in = 16'h1234; mode_a = 0; step();
        cmp("t2_wr_err_mode0", 32'(wr_err), 32'h1);
        mode_a = 1; step(); write = 0;
        cmp("t2_wr_err_mode1", 32'(wr_err), 32'h0);
        rd_addr = 1; step();
        cmp("t2_readback", 32'(Data_out), 32'h1234);

        // 3: full session with zeroize on entry and exit
        for (int i = 0; i < N; i++) begin
            write = 1; wr_addr = 3'(i); Data_in = 16'(16'h1000 + i); mode_a = 1; step();
        end
        write = 0;
        rd_addr = 0; step();
        cmp("t3_preload", 32'(Data_out), 32'h1000);
        send_key(K0); step(); step();
        send_key(K1);
        count_busy(nb);
        cmp("t3_zero_in_cycles", nb, 8);
        cmp("t3_dbg_active", 32'(dbg_active), 32'h1);
        for (int i = 0; i < N; i++) begin
            rd_addr = 3'(i); step();
            cmp("t3_zeroed", 32'(Data_out), 32'h0);
        end
        write = 1; wr_addr = 2; Data_in = 16'hCAFE; mode_a = 0; step(); write = 0;
        cmp("t3_session_wr_err", 32'(wr_err), 32'h0);
        rd_addr = 2; step();
        cmp("t3_session_write", 32'(Data_out), 32'hCAFE);
        dbg_exit = 1; step(); dbg_exit = 0;
        count_busy(nb);
        cmp("t3_zero_out_cycles", nb, 8);
        rd_addr = 2; step();
        cmp("t3_reg2_after_exit", 32'(Data_out), 32'h0);
        cmp("t3_mask_kept", 32'(locked_mask), 32'h04);
        cmp("t3_inactive", 32'(dbg_active), 32'h0);

        // 4a: KEY1 on the last ARMED cycle is still accepted
        send_key(K0);
        repeat (TMO - 1) step();
        send_key(K1);
        cmp("t4_last_cycle_key1", 32'(zero_busy), 32'h1);
        count_busy(nb);
        cmp("t4_session", 32'(dbg_active), 32'h1);
        dbg_exit = 1; step(); dbg_exit = 0;
        count_busy(nb);
        // 4b: challenge lapses after TIMEOUT cycles
        send_key(K0);
        repeat (TMO) step();
        send_key(K1);
        step();
        cmp("t4_timeout_busy",   32'(zero_busy), 32'h0);
        cmp("t4_timeout_active", 32'(dbg_active), 32'h0);
        cmp("t4_timeout_lock",   32'(lockout), 32'h0);

        // 5: lockout after three wrong keys
        reset = 1; step(); reset = 0;
        for (int i = 0; i < MAXF; i++) begin
            do k = $urandom; while (k == K0);
            send_key(k);
            cmp("t5_lockout_edge", 32'(lockout), 32'(i == MAXF - 1));
        end
        send_key(K0); send_key(K1); step();
        cmp("t5_no_session", 32'(dbg_active), 32'h0);
        cmp("t5_no_zero",    32'(zero_busy), 32'h0);
        cmp("t5_still_lock", 32'(lockout), 32'h1);
        Lock = 1; lock_addr = 6; step(); Lock = 0;
        reset = 1; step(); reset = 0;
        cmp("t5_rst_lockout", 32'(lockout), 32'h0);
        cmp("t5_rst_mask",    32'(locked_mask), 32'h0);

        // 6: lock beats same-cycle write; reset during zeroize
        Lock = 1; lock_addr = 5; write = 1; wr_addr = 5; Data_in = 16'h5555; mode_a = 1;
        step();
        Lock = 0; write = 0;
        cmp("t6_wr_err", 32'(wr_err), 32'h1);
        cmp("t6_mask",   32'(locked_mask), 32'h20);
        rd_addr = 5; step();
        cmp("t6_reg5",   32'(Data_out), 32'h0);
        send_key(K0); send_key(K1); step(); step();
        cmp("t6_in_zero", 32'(zero_busy), 32'h1);
        reset = 1; step(); reset = 0;
        cmp("t6_rst_busy",   32'(zero_busy), 32'h0);
        cmp("t6_rst_active", 32'(dbg_active), 32'h0);
        cmp("t6_rst_mask",   32'(locked_mask), 32'h0);
        cmp("t6_rst_wr_err", 32'(wr_err), 32'h0);

        // Randomized traffic, checked cycle by cycle against the model
        repeat (3000) begin
            reset    = ($urandom_range(0, 299) == 0);
            write    = $urandom_range(0, 1) == 1;
            mode_a   = ($urandom_range(0, 3) != 0);
            wr_addr  = 3'($urandom);
            rd_addr  = 3'($urandom);
            Data_in  = 16'($urandom);
            Lock     = ($urandom_range(0, 39) == 0);
            lock_addr = 3'($urandom);
            lock_all = ($urandom_range(0, 599) == 0);
            dbg_exit = ($urandom_range(0, 15) == 0);
            dbg_req  = ($urandom_range(0, 5) == 0);
            case ($urandom_range(0, 9))
                0, 1, 2, 3: dbg_key = K0;
                4, 5, 6, 7: dbg_key = K1;
                default:    dbg_key = $urandom;
            endcase
            step();
        end

        clear_in();
        step();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
